pulse_width_meter: RTL and testbench

Receive-side companion to the delay line blocks. It samples an asynchronous single-bit pulse stream (idata) and measures the high time of each pulse in iclock cycles. Each measurement is presented on a valid/ready result port. Benches use it to check delayed pulse streams, and it is reused in the design to decode pulse-width encoded strobes.

---
 rtl/pulse_width_meter.sv | 129 ++++++++++++
 tb/tb_pulse_width_meter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_meter.sv
// Measures the high time, in iclock cycles, of each pulse on an asynchronous
// input and presents every measurement on a valid/ready result port.
module pulse_width_meter #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             iclock,
    input  logic             irst_n,
    input  logic             idata,
    input  logic             iready,
    output logic             ovalid,
    output logic [CNT_W-1:0] owidth,
    output logic             osat,
    output logic             odrop,
    output logic             obusy
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam int unsigned      ARM_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_FILL = ARM_W'(SYNC_STAGES);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_IDLE,
        ST_MEASURE
    } state_t;

    state_t                 state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       cnt_q, cnt_nxt;
    logic                   sat_q, sat_nxt;
    logic [ARM_W-1:0]       arm_q, arm_nxt;
    logic                   complete_c, load_c;

    assign s      = sync_q[SYNC_STAGES-1];
    assign rise   = s & ~s_d;
    assign load_c = ~ovalid | iready;

    // Input synchroniser and one-cycle delayed copy for edge detection
    always_ff @(posedge iclock or negedge irst_n) begin
        if (!irst_n) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], idata};
            s_d    <= s;
        end
    end

    // State, count and arm-flush registers
    always_ff @(posedge iclock or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= ST_ARM;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            arm_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            sat_q   <= sat_nxt;
            arm_q   <= arm_nxt;
        end
    end

    // ARM lets the reset zeros drain out of the synchroniser before trusting s,
    // so a pulse already high at reset release never produces a rise.
    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        sat_nxt    = sat_q;
        arm_nxt    = arm_q;
        complete_c = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (arm_q != ARM_FILL) begin
                    arm_nxt = arm_q + ARM_W'(1);
                end else if (!s) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (rise) begin
                    state_nxt = ST_MEASURE;
                    cnt_nxt   = CNT_W'(1);
                    sat_nxt   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (s) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_nxt  = ST_IDLE;
                    complete_c = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ARM;
            end
        endcase
    end

    // Result register: a completion is loaded only if the slot is free or
    // being emptied on the same edge; otherwise it is dropped and flagged.
    always_ff @(posedge iclock or negedge irst_n) begin
        if (!irst_n) begin
            ovalid <= 1'b0;
            owidth <= '0;
            osat   <= 1'b0;
            odrop  <= 1'b0;
            obusy  <= 1'b0;
        end else begin
            odrop <= complete_c & ~load_c;
            obusy <= (state_nxt == ST_MEASURE);
            if (complete_c && load_c) begin
                ovalid <= 1'b1;
                owidth <= cnt_q;
                osat   <= sat_q;
            end else if (ovalid && iready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// Directed bench for pulse_width_meter: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every result transfer.
module tb_pulse_width_meter;

    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SYNC_STAGES = 2;

    typedef logic [CNT_W:0] res_t;  // {sat, width}

    logic             iclock;
    logic             irst_n;
    logic             idata;
    logic             iready;
    logic             ovalid;
    logic [CNT_W-1:0] owidth;
    logic             osat;
    logic             odrop;
    logic             obusy;

    int   checks      = 0;
    int   errors      = 0;
    int   valid_cycles = 0;
    int   drop_cnt    = 0;
    int   xfer_cnt    = 0;
    res_t exp_q[$];

    pulse_width_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .iclock(iclock),
        .irst_n(irst_n),
        .idata (idata),
        .iready(iready),
        .ovalid(ovalid),
        .owidth(owidth),
        .osat  (osat),
        .odrop (odrop),
        .obusy (obusy)
    );

    initial iclock = 1'b0;
    always #5 iclock = ~iclock;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t mk(input int sat, input int width);
        return {1'(sat), CNT_W'(width)};
    endfunction

    // Monitor: samples just after each falling edge, i.e. the values the next rising edge uses
    initial begin
        logic prev_hold;
        logic prev_drop;
        res_t prev_data;
        res_t e;
        prev_hold = 1'b0;
        prev_drop = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge iclock);
            #1;
            if (!irst_n) begin
                prev_hold = 1'b0;
                prev_drop = 1'b0;
            end else begin
                if (prev_hold) begin
                    check("hold_valid", int'(ovalid), 1);
                    check("hold_data", int'({osat, owidth}), int'(prev_data));
                end
                if (ovalid) valid_cycles++;
                if (odrop) begin
                    drop_cnt++;
                    check("odrop_one_cycle", int'(prev_drop), 0);
                end
                if (ovalid && iready) begin
                    xfer_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got width %0d sat %0d, none expected at %0t",
                                 owidth, osat, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", int'({osat, owidth}), int'(e));
                    end
                end
                prev_hold = ovalid & ~iready;
                prev_data = {osat, owidth};
                prev_drop = odrop;
            end
        end
    end

    task automatic pulse(input int n, input int gap);
        @(negedge iclock);
        idata = 1'b1;
        repeat (n) @(negedge iclock);
        idata = 1'b0;
        repeat (gap) @(negedge iclock);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !ovalid) break;
            @(negedge iclock);
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int drop_base;
        int xfer_base;
        idata  = 1'b0;
        iready = 1'b1;
        irst_n = 1'b0;
        #1;
        check("reset_ovalid", int'(ovalid), 0);
        check("reset_obusy", int'(obusy), 0);
        check("reset_odrop", int'(odrop), 0);
        check("reset_owidth", int'({osat, owidth}), 0);
        #19;
        irst_n = 1'b1;
        repeat (4) @(negedge iclock);

        // Pulse timing: widths 1, 2, 3 with iready held high
        valid_cycles = 0;
        exp_q.push_back(mk(0, 1)); pulse(1, 3);
        exp_q.push_back(mk(0, 2)); pulse(2, 3);
        exp_q.push_back(mk(0, 3)); pulse(3, 5);
        wait_drain("drain_timing", 40);
        repeat (3) @(negedge iclock);
        check("timing_valid_cycles", valid_cycles, 3);
        check("timing_drops", drop_cnt, 0);

        // Saturation then a normal pulse
        exp_q.push_back(mk(1, 15)); pulse(20, 4);
        exp_q.push_back(mk(0, 5));  pulse(5, 5);
        wait_drain("drain_sat", 40);

        // Backpressure: second completion is dropped
        iready    = 1'b0;
        drop_base = drop_cnt;
        exp_q.push_back(mk(0, 4)); pulse(4, 4);
        pulse(6, 6);
        check("bp_valid", int'(ovalid), 1);
        check("bp_width", int'(owidth), 4);
        check("bp_drops", drop_cnt - drop_base, 1);
        iready = 1'b1;
        repeat (2) @(negedge iclock);
        check("bp_valid_cleared", int'(ovalid), 0);
        check("bp_queue", exp_q.size(), 0);

        // Simultaneous: transfer of 3 and load of 7 on the same edge
        iready    = 1'b0;
        drop_base = drop_cnt;
        exp_q.push_back(mk(0, 3)); pulse(3, 4);
        check("sim_pending", int'({ovalid, owidth}), int'({1'b1, CNT_W'(3)}));
        exp_q.push_back(mk(0, 7));
        @(negedge iclock);
        idata = 1'b1;
        repeat (7) @(negedge iclock);
        idata = 1'b0;
        repeat (2) @(negedge iclock);
        iready = 1'b1;
        @(negedge iclock);
        iready = 1'b0;
        check("sim_new_valid", int'(ovalid), 1);
        check("sim_new_width", int'(owidth), 7);
        check("sim_queue", exp_q.size(), 1);
        repeat (2) @(negedge iclock);
        check("sim_drops", drop_cnt - drop_base, 0);
        iready = 1'b1;
        wait_drain("drain_sim", 20);

        // Pulse high across reset release is ignored
        @(negedge iclock);
        irst_n = 1'b0;
        idata  = 1'b1;
        repeat (2) @(negedge iclock);
        irst_n = 1'b1;
        repeat (8) @(negedge iclock);
        idata = 1'b0;
        repeat (4) @(negedge iclock);
        exp_q.push_back(mk(0, 2)); pulse(2, 5);
        wait_drain("drain_arm", 20);

        // Reset mid-MEASURE with a result pending
        iready = 1'b0;
        pulse(3, 5);
        check("rst_pending", int'({ovalid, owidth}), int'({1'b1, CNT_W'(3)}));
        @(negedge iclock);
        idata = 1'b1;
        for (int i = 0; i < 10 && !obusy; i++) @(negedge iclock);
        check("rst_busy_before", int'(obusy), 1);
        #2;
        irst_n = 1'b0;
        #1;
        check("rst_ovalid", int'(ovalid), 0);
        check("rst_obusy", int'(obusy), 0);
        check("rst_odrop", int'(odrop), 0);
        @(negedge iclock);
        idata = 1'b0;
        repeat (2) @(negedge iclock);
        irst_n = 1'b1;
        iready = 1'b1;
        repeat (5) @(negedge iclock);
        check("rst_no_result", int'(ovalid), 0);

        // Minimum gap: 3 high, 1 low, 3 high
        xfer_base = xfer_cnt;
        exp_q.push_back(mk(0, 3));
        exp_q.push_back(mk(0, 3));
        @(negedge iclock);
        idata = 1'b1;
        repeat (3) @(negedge iclock);
        idata = 1'b0;
        @(negedge iclock);
        idata = 1'b1;
        repeat (3) @(negedge iclock);
        idata = 1'b0;
        repeat (6) @(negedge iclock);
        wait_drain("drain_gap", 20);
        check("gap_transfers", xfer_cnt - xfer_base, 2);

        repeat (4) @(negedge iclock);
        check("final_queue", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
